rf_port_arbiter: RTL and testbench

Shares the single-access register file between two requesters: the core control path (port C) and the debug/loader path (port D). Each request becomes one register-file operation: a read of two registers, or a write of one. The block sequences the register file's WE/RE strobes and address/data lines through a three-state FSM. It returns registered read data with a one-cycle response pulse to whichever requester was granted.

---
 rtl/rf_arb_pkg.sv | 21 ++
 rtl/rr_arb2.sv | 19 +
 rtl/rf_port_arbiter.sv | 130 +++++++++++++
 tb/tb_rf_port_arbiter.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_arb_pkg.sv
// Shared types and constants for the register-file port arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rf_arb_pkg;

    // Arbiter sequencing states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    // Requester IDs; also the bit index of each port in req/gnt vectors.
    localparam logic PORT_C = 1'b0;
    localparam logic PORT_D = 1'b1;

    // Default register address and data widths.
    localparam int AW_DEF = 5;
    localparam int DW_DEF = 32;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin grant: a tie goes to the port that did not win last time.
// Latency: combinational.
// Backpressure: none; gnt is one-hot, or zero when nothing is requested.
module rr_arb2
    import rf_arb_pkg::*;
(
    input  logic [1:0] req,   // bit PORT_C = core, bit PORT_D = debug
    input  logic       last,  // port granted most recently
    output logic [1:0] gnt
);

    always_comb begin
        gnt = req;
        if (&req) begin
            gnt = (last == PORT_D) ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/rf_port_arbiter.sv
// Shares a single-access register file between core (C) and debug (D) ports; optional x0 guard via RF_ARB_X0_GUARD_EN.
// Latency: accept at T, rf strobe at T+1, rsp_valid and read data at T+2; one operation per 3 cycles.
// Backpressure: c_ready/d_ready are combinational grants, high only in IDLE; no new grant while busy.
module rf_port_arbiter
    import rf_arb_pkg::*;
#(
    parameter int AW = AW_DEF,
    parameter int DW = DW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    // Core-control port
    input  logic          c_valid,
    output logic          c_ready,
    input  logic          c_we,
    input  logic [AW-1:0] c_addr_a,
    input  logic [AW-1:0] c_addr_b,
    input  logic [DW-1:0] c_wdata,
    output logic          c_rsp_valid,
    // Debug/loader port
    input  logic          d_valid,
    output logic          d_ready,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr_a,
    input  logic [AW-1:0] d_addr_b,
    input  logic [DW-1:0] d_wdata,
    output logic          d_rsp_valid,
    // Shared response data
    output logic [DW-1:0] rsp_rd1,
    output logic [DW-1:0] rsp_rd2,
    // Register-file side
    output logic          rf_we,
    output logic          rf_re,
    output logic [AW-1:0] rf_rw_addr,
    output logic [AW-1:0] rf_rd1_addr,
    output logic [DW-1:0] rf_wr1,
    input  logic [DW-1:0] rf_rd1,
    input  logic [DW-1:0] rf_rd2
);

`ifdef RF_ARB_X0_GUARD_EN
    localparam bit X0_GUARD = 1'b1;
`else
    localparam bit X0_GUARD = 1'b0;
`endif

    state_t        state;
    logic          last_grant;  // also identifies the in-flight requester
    logic          lat_we;
    logic [1:0]    req_vld;
    logic [1:0]    gnt;
    logic          sel_d;
    logic          sel_we;
    logic [AW-1:0] sel_addr_a;
    logic [AW-1:0] sel_addr_b;
    logic [DW-1:0] sel_wdata;

    assign req_vld = {d_valid, c_valid};

    rr_arb2 u_rr_arb2 (
        .req  (req_vld),
        .last (last_grant),
        .gnt  (gnt)
    );

    assign c_ready = (state == IDLE) & gnt[PORT_C];
    assign d_ready = (state == IDLE) & gnt[PORT_D];

    // Request fields of whichever port wins this cycle.
    assign sel_d      = gnt[PORT_D];
    assign sel_we     = sel_d ? d_we     : c_we;
    assign sel_addr_a = sel_d ? d_addr_a : c_addr_a;
    assign sel_addr_b = sel_d ? d_addr_b : c_addr_b;
    assign sel_wdata  = sel_d ? d_wdata  : c_wdata;

    // rf_rw_addr/rf_rd1_addr/rf_wr1 double as the request latch: they only
    // change on a grant, so they hold between operations.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            last_grant  <= PORT_D;
            lat_we      <= 1'b0;
            rf_we       <= 1'b0;
            rf_re       <= 1'b0;
            rf_rw_addr  <= '0;
            rf_rd1_addr <= '0;
            rf_wr1      <= '0;
            rsp_rd1     <= '0;
            rsp_rd2     <= '0;
            c_rsp_valid <= 1'b0;
            d_rsp_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (|gnt) begin
                        last_grant  <= sel_d ? PORT_D : PORT_C;
                        lat_we      <= sel_we;
                        rf_rw_addr  <= sel_addr_a;
                        rf_rd1_addr <= sel_addr_b;
                        rf_wr1      <= sel_wdata;
                        // Guarded x0 writes still run the full sequence, just without the strobe.
                        rf_we       <= sel_we & ~(X0_GUARD && (sel_addr_a == '0));
                        rf_re       <= ~sel_we;
                        state       <= ACCESS;
                    end
                end
                ACCESS: begin
                    rf_we <= 1'b0;
                    rf_re <= 1'b0;
                    if (!lat_we) begin
                        rsp_rd1 <= (X0_GUARD && (rf_rw_addr  == '0)) ? '0 : rf_rd1;
                        rsp_rd2 <= (X0_GUARD && (rf_rd1_addr == '0)) ? '0 : rf_rd2;
                    end
                    c_rsp_valid <= (last_grant == PORT_C);
                    d_rsp_valid <= (last_grant == PORT_D);
                    state       <= RESP;
                end
                RESP: begin
                    c_rsp_valid <= 1'b0;
                    d_rsp_valid <= 1'b0;
                    state       <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rf_port_arbiter.sv
// Directed self-checking bench for rf_port_arbiter with a behavioural register file.
// Latency: inputs driven and outputs sampled 1 time unit after each rising edge.
// Backpressure: requests are held or dropped explicitly by each directed step.
module tb_rf_port_arbiter;

    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          c_valid, c_ready, c_we, c_rsp_valid;
    logic          d_valid, d_ready, d_we, d_rsp_valid;
    logic [AW-1:0] c_addr_a, c_addr_b, d_addr_a, d_addr_b;
    logic [DW-1:0] c_wdata, d_wdata;
    logic [DW-1:0] rsp_rd1, rsp_rd2;
    logic          rf_we, rf_re;
    logic [AW-1:0] rf_rw_addr, rf_rd1_addr;
    logic [DW-1:0] rf_wr1, rf_rd1, rf_rd2;

    int n_chk  = 0;
    int n_fail = 0;

`ifdef RF_ARB_X0_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    always #5 clk = ~clk;

    rf_port_arbiter #(.AW(AW), .DW(DW)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .c_valid     (c_valid),
        .c_ready     (c_ready),
        .c_we        (c_we),
        .c_addr_a    (c_addr_a),
        .c_addr_b    (c_addr_b),
        .c_wdata     (c_wdata),
        .c_rsp_valid (c_rsp_valid),
        .d_valid     (d_valid),
        .d_ready     (d_ready),
        .d_we        (d_we),
        .d_addr_a    (d_addr_a),
        .d_addr_b    (d_addr_b),
        .d_wdata     (d_wdata),
        .d_rsp_valid (d_rsp_valid),
        .rsp_rd1     (rsp_rd1),
        .rsp_rd2     (rsp_rd2),
        .rf_we       (rf_we),
        .rf_re       (rf_re),
        .rf_rw_addr  (rf_rw_addr),
        .rf_rd1_addr (rf_rd1_addr),
        .rf_wr1      (rf_wr1),
        .rf_rd1      (rf_rd1),
        .rf_rd2      (rf_rd2)
    );

    // Behavioural register file: combinational reads, write on the rising edge.
    // Loaded with rf[i] = i + 3 while rf_load is high.
    logic [DW-1:0] rf [32];
    logic          rf_load;

    always @(posedge clk) begin
        if (rf_load) begin
            for (int i = 0; i < 32; i++) rf[i] <= DW'(i + 3);
        end else if (rf_we) begin
            rf[rf_rw_addr] <= rf_wr1;
        end
    end

    assign rf_rd1 = rf[rf_rw_addr];
    assign rf_rd2 = rf[rf_rd1_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic go;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n   = 1'b0;
        rf_load = 1'b1;
        c_valid = 1'b0; c_we = 1'b0; c_addr_a = '0; c_addr_b = '0; c_wdata = '0;
        d_valid = 1'b0; d_we = 1'b0; d_addr_a = '0; d_addr_b = '0; d_wdata = '0;
        go;
        go;
        rf_load = 1'b0;

        // Reset state
        chk("rst_c_ready", {31'd0, c_ready}, 32'd0);
        chk("rst_d_ready", {31'd0, d_ready}, 32'd0);
        chk("rst_rsp_vld", {30'd0, c_rsp_valid, d_rsp_valid}, 32'd0);
        chk("rst_rsp_rd1", rsp_rd1, 32'd0);
        chk("rst_rsp_rd2", rsp_rd2, 32'd0);
        chk("rst_strobes", {30'd0, rf_we, rf_re}, 32'd0);
        chk("rst_rf_addr", {22'd0, rf_rw_addr, rf_rd1_addr}, 32'd0);
        chk("rst_rf_wr1", rf_wr1, 32'd0);
        rst_n = 1'b1;
        go;
        chk("idle_strobes", {30'd0, rf_we, rf_re}, 32'd0);

        // Single C read of (3,4): rf holds 6/7
        c_valid = 1'b1; c_we = 1'b0; c_addr_a = 5'd3; c_addr_b = 5'd4;
        #1;
        chk("rd_c_ready", {31'd0, c_ready}, 32'd1);
        chk("rd_d_ready", {31'd0, d_ready}, 32'd0);
        go;
        c_valid = 1'b0;
        chk("rd_access_strobes", {30'd0, rf_we, rf_re}, 32'd1);
        chk("rd_rw_addr", {27'd0, rf_rw_addr}, 32'd3);
        chk("rd_rd1_addr", {27'd0, rf_rd1_addr}, 32'd4);
        chk("rd_busy_ready", {31'd0, c_ready}, 32'd0);
        go;
        chk("rd_rsp_vld", {30'd0, c_rsp_valid, d_rsp_valid}, 32'd2);
        chk("rd_rsp_rd1", rsp_rd1, 32'd6);
        chk("rd_rsp_rd2", rsp_rd2, 32'd7);
        chk("rd_resp_strobes", {30'd0, rf_we, rf_re}, 32'd0);
        go;
        chk("rd_done_rsp_vld", {30'd0, c_rsp_valid, d_rsp_valid}, 32'd0);

        // D write of DEADBEEF to x9
        d_valid = 1'b1; d_we = 1'b1; d_addr_a = 5'd9; d_addr_b = 5'd1; d_wdata = 32'hDEAD_BEEF;
        #1;
        chk("wr_d_ready", {31'd0, d_ready}, 32'd1);
        chk("wr_c_ready", {31'd0, c_ready}, 32'd0);
        go;
        d_valid = 1'b0;
        chk("wr_access_strobes", {30'd0, rf_we, rf_re}, 32'd2);
        chk("wr_rw_addr", {27'd0, rf_rw_addr}, 32'd9);
        chk("wr_rf_wr1", rf_wr1, 32'hDEAD_BEEF);
        go;
        chk("wr_we_one_cycle", {31'd0, rf_we}, 32'd0);
        chk("wr_rsp_vld", {30'd0, c_rsp_valid, d_rsp_valid}, 32'd1);
        chk("wr_rsp_rd1_held", rsp_rd1, 32'd6);
        go;

        // C read of (9,3) sees the written value
        c_valid = 1'b1; c_we = 1'b0; c_addr_a = 5'd9; c_addr_b = 5'd3;
        #1;
        chk("rb_c_ready", {31'd0, c_ready}, 32'd1);
        go;
        c_valid = 1'b0;
        go;
        chk("rb_rsp_vld", {30'd0, c_rsp_valid, d_rsp_valid}, 32'd2);
        chk("rb_rsp_rd1", rsp_rd1, 32'hDEAD_BEEF);
        chk("rb_rsp_rd2", rsp_rd2, 32'd6);
        go;

        // Reset during ACCESS of a D write to x10: write is lost
        d_valid = 1'b1; d_we = 1'b1; d_addr_a = 5'd10; d_addr_b = 5'd0; d_wdata = 32'h0000_0055;
        #1;
        chk("mr_d_ready", {31'd0, d_ready}, 32'd1);
        go;
        d_valid = 1'b0;
        chk("mr_access_we", {31'd0, rf_we}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mr_reset_we", {31'd0, rf_we}, 32'd0);
        chk("mr_reset_addr", {27'd0, rf_rw_addr}, 32'd0);
        go;
        chk("mr_next_we", {31'd0, rf_we}, 32'd0);
        chk("mr_next_rsp_vld", {30'd0, c_rsp_valid, d_rsp_valid}, 32'd0);
        rst_n = 1'b1;

        // Continuous contention: C,D,C,D at 3-cycle spacing, C first after reset
        c_valid = 1'b1; c_we = 1'b0; c_addr_a = 5'd1; c_addr_b = 5'd2;
        d_valid = 1'b1; d_we = 1'b0; d_addr_a = 5'd5; d_addr_b = 5'd6;
        #1;
        for (int k = 0; k < 4; k++) begin
            logic exp_d;
            exp_d = k[0];
            chk("rr_c_ready", {31'd0, c_ready}, {31'd0, ~exp_d});
            chk("rr_d_ready", {31'd0, d_ready}, {31'd0, exp_d});
            go;
            chk("rr_access_ready", {30'd0, c_ready, d_ready}, 32'd0);
            chk("rr_rw_addr", {27'd0, rf_rw_addr}, exp_d ? 32'd5 : 32'd1);
            go;
            chk("rr_rsp_vld", {30'd0, c_rsp_valid, d_rsp_valid}, exp_d ? 32'd1 : 32'd2);
            chk("rr_rsp_rd1", rsp_rd1, exp_d ? 32'd8 : 32'd4);
            chk("rr_rsp_rd2", rsp_rd2, exp_d ? 32'd9 : 32'd5);
            chk("rr_resp_ready", {30'd0, c_ready, d_ready}, 32'd0);
            go;
        end
        c_valid = 1'b0;
        d_valid = 1'b0;

        // x10 still holds its load value; during RESP a one-cycle D pulse is ignored
        c_valid = 1'b1; c_we = 1'b0; c_addr_a = 5'd10; c_addr_b = 5'd2;
        #1;
        chk("lost_c_ready", {31'd0, c_ready}, 32'd1);
        go;
        c_valid = 1'b0;
        go;
        chk("lost_rsp_rd1", rsp_rd1, 32'd13);
        chk("lost_rsp_rd2", rsp_rd2, 32'd5);
        d_valid = 1'b1; d_we = 1'b0; d_addr_a = 5'd1; d_addr_b = 5'd1;
        #1;
        chk("pulse_resp_d_ready", {31'd0, d_ready}, 32'd0);
        go;
        d_valid = 1'b0;
        #1;
        chk("pulse_idle_d_ready", {31'd0, d_ready}, 32'd0);
        go;
        chk("pulse_no_strobe", {30'd0, rf_we, rf_re}, 32'd0);
        chk("pulse_no_rsp1", {30'd0, c_rsp_valid, d_rsp_valid}, 32'd0);
        go;
        chk("pulse_no_rsp2", {30'd0, c_rsp_valid, d_rsp_valid}, 32'd0);
        chk("pulse_still_idle", {30'd0, rf_we, rf_re}, 32'd0);

        // Write to x0, then read (0,1)
        c_valid = 1'b1; c_we = 1'b1; c_addr_a = 5'd0; c_addr_b = 5'd0; c_wdata = 32'h0000_0077;
        #1;
        chk("x0_wr_ready", {31'd0, c_ready}, 32'd1);
        go;
        c_valid = 1'b0;
        chk("x0_wr_we", {31'd0, rf_we}, GUARD ? 32'd0 : 32'd1);
        go;
        chk("x0_wr_rsp_vld", {30'd0, c_rsp_valid, d_rsp_valid}, 32'd2);
        go;
        c_valid = 1'b1; c_we = 1'b0; c_addr_a = 5'd0; c_addr_b = 5'd1;
        #1;
        chk("x0_rd_ready", {31'd0, c_ready}, 32'd1);
        go;
        c_valid = 1'b0;
        go;
        chk("x0_rd_rsp_rd1", rsp_rd1, GUARD ? 32'd0 : 32'h0000_0077);
        chk("x0_rd_rsp_rd2", rsp_rd2, 32'd4);
        go;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
